// File: rtl/mm_sched_pkg.sv
// mm_pkg: mode codes, controller state codes and scheduler states for mm_sched
package mm_pkg;

   typedef enum logic [2:0] {
      MODE_IDLE = 3'd0,
      MODE_AS   = 3'd1,
      MODE_SA   = 3'd2,
      MODE_SB   = 3'd3,
      MODE_BS   = 3'd4
   } mode_e;

   localparam logic [3:0] AS_WAITHASH = 4'd3;
   localparam logic [3:0] SA_WAITHASH = 4'd7;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREFETCH,
      S_LAUNCH,
      S_RUN,
      S_HASH,
      S_RELEASE,
      S_PARK
   } state_e;

   function automatic logic is_waithash(input logic [3:0] code);
      return code == AS_WAITHASH || code == SA_WAITHASH;
   endfunction

   function automatic logic mode_legal(input logic [2:0] m);
      return m >= 3'd1 && m <= 3'd4;
   endfunction

   // AS and SA consume an A-matrix chunk before the first block
   function automatic logic needs_prefetch(input logic [2:0] m);
      return m == 3'd1 || m == 3'd2;
   endfunction

endpackage

// File: rtl/mm_sched_if.sv
// mm_sched_if: host command, hash generator and memory controller signals around the scheduler
interface mm_sched_if #(parameter int BLK_W = 10);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_mode;
   logic [BLK_W-1:0] cmd_blocks;
   logic             calc_init;
   logic [2:0]       mem_mode;
   logic [3:0]       ctrl_state;
   logic             hash_start;
   logic             hash_done;
   logic             hash_ready;
   logic             abort;
   logic             busy;
   logic             done;
   logic             err;
   logic [BLK_W-1:0] blk_cnt;

   modport master (
      output cmd_valid, cmd_mode, cmd_blocks, ctrl_state, hash_done, abort,
      input  cmd_ready, calc_init, mem_mode, hash_start, hash_ready, busy, done, err, blk_cnt
   );

   modport slave (
      input  cmd_valid, cmd_mode, cmd_blocks, ctrl_state, hash_done, abort,
      output cmd_ready, calc_init, mem_mode, hash_start, hash_ready, busy, done, err, blk_cnt
   );
endinterface

// File: rtl/mm_sched_hash_watchdog.sv
// hash_watchdog: reloads on every hash request and flags expiry when hash_done never arrives
module hash_watchdog #(parameter int HASH_TIMEOUT = 4096) (
   input  logic clk,
   input  logic rst_n,
   input  logic start_i,
   input  logic clear_i,
   output logic expired_o
);
   localparam int CW = $clog2(HASH_TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          armed_q, armed_d;

   // count down from the reload value; reaching zero while armed is the timeout
   always_comb begin
      cnt_d   = start_i ? CW'(HASH_TIMEOUT - 1) : (armed_q && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
      armed_d = start_i | (armed_q & ~clear_i);
   end

   // counter and arm flag registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
      end
   end

   assign expired_o = armed_q && cnt_q == '0;
endmodule

// File: rtl/mm_sched.sv
// mm_sched: sequences prefetch, launch, block counting, hash release and park for the matmul controller
module mm_sched
   import mm_pkg::*;
#(
   parameter int HASH_TIMEOUT = 4096,
   parameter int BLK_W        = 10
) (
   input logic       clk,
   input logic       rst_n,
   mm_sched_if.slave sif
);
   state_e           state_q, state_d;
   mode_e            mode_q, mode_d, mem_mode_q, mem_mode_d;
   logic [BLK_W-1:0] blocks_q, blocks_d, cnt_q, cnt_d, cnt_inc;
   logic             wait_q, boundary, expired, park_done, park_err, bad_cmd;
   logic             calc_init_q, calc_init_d, hash_start_q, hash_start_d;
   logic             hash_ready_q, hash_ready_d, done_q, done_d, err_q, err_d;

   assign boundary = is_waithash(sif.ctrl_state) && !wait_q;
   assign cnt_inc  = cnt_q + 1'b1;

   hash_watchdog #(.HASH_TIMEOUT(HASH_TIMEOUT)) u_wdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (hash_start_d),
      .clear_i   (state_d != S_PREFETCH && state_d != S_HASH),
      .expired_o (expired)
   );

   // next state: abort beats timeout, timeout beats hash_done, hash_done beats a block boundary
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      blocks_d  = blocks_q;
      cnt_d     = cnt_q;
      park_done = 1'b0;
      park_err  = 1'b0;
      bad_cmd   = 1'b0;
      if (state_q == S_IDLE) begin
         if (sif.cmd_valid) begin
            if (!mode_legal(sif.cmd_mode) || sif.cmd_blocks == '0) bad_cmd = 1'b1;
            else begin
               mode_d   = mode_e'(sif.cmd_mode);
               blocks_d = sif.cmd_blocks;
               cnt_d    = '0;
               state_d  = needs_prefetch(sif.cmd_mode) ? S_PREFETCH : S_LAUNCH;
            end
         end
      end else if (sif.abort && state_q != S_PARK) state_d = S_PARK;
      else begin
         case (state_q)
            S_PREFETCH, S_HASH:
               if (expired) begin
                  state_d  = S_PARK;
                  park_err = 1'b1;
               end else if (sif.hash_done) state_d = state_q == S_HASH ? S_RELEASE : S_LAUNCH;
               else if (boundary && state_q == S_HASH) begin
                  state_d  = S_PARK;
                  park_err = 1'b1;
               end
            S_LAUNCH: state_d = S_RUN;
            S_RUN:
               if (boundary) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == blocks_q) begin
                     state_d   = S_PARK;
                     park_done = 1'b1;
                  end else if (!cnt_inc[0]) state_d = S_HASH;
               end
            S_RELEASE: begin
               state_d  = boundary ? S_PARK : S_RUN;
               park_err = boundary;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // registered pulses are decoded from the transition about to be taken
   always_comb begin
      calc_init_d  = state_d == S_LAUNCH || state_d == S_PARK;
      mem_mode_d   = state_d == S_LAUNCH ? mode_d : MODE_IDLE;
      hash_start_d = state_d != state_q && (state_d == S_PREFETCH || state_d == S_HASH);
      hash_ready_d = state_d == S_RELEASE;
      done_d       = park_done;
      err_d        = park_err | bad_cmd;
   end

   // state, command latches and output pulse registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         mode_q       <= MODE_IDLE;
         blocks_q     <= '0;
         cnt_q        <= '0;
         wait_q       <= 1'b0;
         calc_init_q  <= 1'b0;
         mem_mode_q   <= MODE_IDLE;
         hash_start_q <= 1'b0;
         hash_ready_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         blocks_q     <= blocks_d;
         cnt_q        <= cnt_d;
         wait_q       <= is_waithash(sif.ctrl_state);
         calc_init_q  <= calc_init_d;
         mem_mode_q   <= mem_mode_d;
         hash_start_q <= hash_start_d;
         hash_ready_q <= hash_ready_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign sif.cmd_ready  = state_q == S_IDLE;
   assign sif.busy       = state_q != S_IDLE;
   assign sif.blk_cnt    = cnt_q;
   assign sif.calc_init  = calc_init_q;
   assign sif.mem_mode   = mem_mode_q;
   assign sif.hash_start = hash_start_q;
   assign sif.hash_ready = hash_ready_q;
   assign sif.done       = done_q;
   assign sif.err        = err_q;
endmodule
